// File: rtl/reg_2bytes_uart_rx.sv
// rtl/reg_2bytes_uart_rx.sv - pairs two UART receive bytes into one word with an inter-byte timeout
module reg_2bytes_uart_rx #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_WIDTH      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       done_rx,
  input  logic [7:0] data_rx,
  output logic [7:0] byte_one,
  output logic [7:0] byte_two,
  output logic       data_valid,
  output logic       busy,
  output logic       timeout_err
);

  // Last counter value before an orphan first byte is abandoned.
  localparam logic [CNT_WIDTH-1:0] LP_TERM = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_TWO = 2'b01
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_buf_lo;
  logic [7:0]           w_buf_lo_nxt;
  logic [7:0]           r_byte_one;
  logic [7:0]           w_byte_one_nxt;
  logic [7:0]           r_byte_two;
  logic [7:0]           w_byte_two_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_data_valid;
  logic                 w_data_valid_nxt;
  logic                 r_timeout_err;
  logic                 w_timeout_err_nxt;

  // State and datapath registers; reset discards any half-assembled pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_buf_lo      <= 8'h00;
      r_byte_one    <= 8'h00;
      r_byte_two    <= 8'h00;
      r_cnt         <= '0;
      r_data_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_buf_lo      <= w_buf_lo_nxt;
      r_byte_one    <= w_byte_one_nxt;
      r_byte_two    <= w_byte_two_nxt;
      r_cnt         <= w_cnt_nxt;
      r_data_valid  <= w_data_valid_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Next-state logic: capture first byte, then complete the pair or time out.
  always_comb begin
    w_state_nxt       = r_state;
    w_buf_lo_nxt      = r_buf_lo;
    w_byte_one_nxt    = r_byte_one;
    w_byte_two_nxt    = r_byte_two;
    w_cnt_nxt         = r_cnt;
    w_data_valid_nxt  = 1'b0;
    w_timeout_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (done_rx && enable) begin
          w_buf_lo_nxt = data_rx;
          w_state_nxt  = ST_WAIT_TWO;
        end
      end
      ST_WAIT_TWO: begin
        // A strobe on the terminal-count cycle still wins over the timeout.
        if (done_rx) begin
          w_byte_one_nxt   = r_buf_lo;
          w_byte_two_nxt   = data_rx;
          w_data_valid_nxt = 1'b1;
          w_state_nxt      = ST_IDLE;
        end else if (r_cnt == LP_TERM) begin
          w_timeout_err_nxt = 1'b1;
          w_buf_lo_nxt      = 8'h00;
          w_state_nxt       = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        // Corrupted encoding: recover silently.
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign byte_one    = r_byte_one;
  assign byte_two    = r_byte_two;
  assign data_valid  = r_data_valid;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state == ST_WAIT_TWO);

endmodule

// File: tb/tb_reg_2bytes_uart_rx.sv
// tb/tb_reg_2bytes_uart_rx.sv - scoreboard bench for reg_2bytes_uart_rx
module tb_reg_2bytes_uart_rx;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       done_rx;
  logic [7:0] data_rx;
  logic [7:0] byte_one;
  logic [7:0] byte_two;
  logic       data_valid;
  logic       busy;
  logic       timeout_err;

  typedef struct {
    logic [1:0] kind;   // 2'b10 = pair delivered, 2'b01 = timeout
    logic [7:0] b1;
    logic [7:0] b2;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] exp_b1;
  logic [7:0] exp_b2;

  reg_2bytes_uart_rx #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .done_rx(done_rx), .data_rx(data_rx),
    .byte_one(byte_one), .byte_two(byte_two), .data_valid(data_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every pulse must match the oldest expected event, in content and cycle.
  always @(negedge clk) begin
    if (!reset && (data_valid || timeout_err)) begin
      if (q.size() == 0) begin
        chk("spurious_pulse", {30'd0, data_valid, timeout_err}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {30'd0, data_valid, timeout_err}, {30'd0, e.kind});
        chk("pulse_cycle", cyc, e.cyc);
        chk("byte_one", byte_one, e.b1);
        chk("byte_two", byte_two, e.b2);
      end
    end
  end

  task automatic push(input logic [1:0] k, input logic [7:0] b1, input logic [7:0] b2, input int c);
    exp_t e;
    e.kind = k; e.b1 = b1; e.b2 = b2; e.cyc = c;
    q.push_back(e);
  endtask

  // Entered and left at posedge+1; the strobe is sampled on the next edge.
  task automatic send(input logic [7:0] d);
    done_rx = 1'b1;
    data_rx = d;
    @(posedge clk); #1;
    done_rx = 1'b0;
    data_rx = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Second byte sampled k edges after the first.
  task automatic do_pair(input logic [7:0] b1, input logic [7:0] b2, input int k);
    int c;
    c = cyc + 1;
    push(2'b10, b1, b2, c + k);
    exp_b1 = b1; exp_b2 = b2;
    send(b1);
    chk("busy_after_first", busy, 1);
    idle(k - 1);
    send(b2);
    chk("busy_after_pair", busy, 0);
  endtask

  task automatic do_timeout(input logic [7:0] b);
    int c;
    c = cyc + 1;
    push(2'b01, exp_b1, exp_b2, c + TO);
    send(b);
    chk("busy_wait", busy, 1);
    idle(TO + 2);
    chk("busy_after_to", busy, 0);
  endtask

  initial begin
    int c;
    reset = 1'b1; enable = 1'b0; done_rx = 1'b0; data_rx = 8'h00;
    exp_b1 = 8'h00; exp_b2 = 8'h00;
    idle(2);
    chk("rst_busy", busy, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_b1", byte_one, 0);
    chk("rst_b2", byte_two, 0);
    reset = 1'b0;
    idle(1);

    // Basic pair, then timeout keeps old bytes, then resync.
    enable = 1'b1;
    do_pair(8'hA5, 8'h3C, 10);
    idle(3);
    do_timeout(8'h11);
    chk("hold_b1", byte_one, 8'hA5);
    chk("hold_b2", byte_two, 8'h3C);
    do_pair(8'h22, 8'h33, 5);
    idle(2);
    do_pair(8'hC3, 8'h5A, 1);
    idle(2);

    // Second strobe on the terminal-count cycle is accepted.
    do_pair(8'h66, 8'h77, TO);
    idle(2);

    // One cycle late: timeout, and the late byte starts a new pair.
    c = cyc + 1;
    push(2'b01, exp_b1, exp_b2, c + TO);
    push(2'b10, 8'h77, 8'h78, c + TO + 2);
    send(8'h66);
    idle(TO);
    send(8'h77);
    chk("late_busy", busy, 1);
    send(8'h78);
    exp_b1 = 8'h77; exp_b2 = 8'h78;
    idle(2);

    // Gating: disabled strobe is ignored; enable only matters for byte one.
    enable = 1'b0;
    send(8'h55);
    chk("gated_busy", busy, 0);
    idle(TO + 4);
    enable = 1'b1;
    c = cyc + 1;
    push(2'b10, 8'h01, 8'h02, c + 3);
    send(8'h01);
    enable = 1'b0;
    idle(2);
    send(8'h02);
    exp_b1 = 8'h01; exp_b2 = 8'h02;
    idle(2);
    chk("gated_b1", byte_one, 8'h01);
    chk("gated_b2", byte_two, 8'h02);

    // Asynchronous reset mid-pair.
    enable = 1'b1;
    send(8'h99);
    chk("pre_rst_busy", busy, 1);
    idle(3);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", data_valid, 0);
    chk("arst_to", timeout_err, 0);
    chk("arst_b1", byte_one, 0);
    chk("arst_b2", byte_two, 0);
    exp_b1 = 8'h00; exp_b2 = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    do_timeout(8'hAB);
    idle(4);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
